// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC source codes,
// the bubble instruction and the fetch FSM state type.
package pipe_pkg;

  // pcsource encodings driven back from ID
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // Instruction word placed in IF/ID when no real instruction is available
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // IDLE: first cycle after reset, FETCH: request outstanding,
  // HELD: a fetched word waits in the skid register while ID is stalled
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection. A redirect decided by ID this cycle wins over a
// redirect remembered from an earlier cycle, which wins over PC+4.
module pipe_npc_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  input  logic            redirect_now,
  input  logic            redir_v,
  input  logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] npc
);

  // Priority select of the address used when the PC next advances
  always_comb begin
    npc = pc + XLEN'(4);
    if (redirect_now) begin
      case (pcsource)
        PCSRC_BR: npc = bpc;
        PCSRC_JR: npc = rpc;
        PCSRC_J:  npc = jpc;
        default:  npc = pc + XLEN'(4);
      endcase
    end else if (redir_v) begin
      npc = redir_pc;
    end
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Drives a
// variable-latency req/ack instruction port, buffers one word in a skid
// register when ID stalls on the ack cycle, and implements a single
// branch delay slot: the fetch in flight when ID redirects always
// completes, and only the fetch after it goes to the target.
module pipe_if_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] dpc4,
  output logic            id_valid
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_plus4, npc;
  logic [XLEN-1:0] redir_pc, skid, skid_pc4;
  logic            redir_v, redirect_now, advance;

  assign pc_plus4     = pc + XLEN'(4);
  assign imem_addr    = pc;
  // ID only redirects on the cycle it actually consumes a valid instruction
  assign redirect_now = id_valid & ~stall & (pcsource != PCSRC_SEQ);
  // The PC moves on when a fetched word is handed to ID (fresh or from skid)
  assign advance      = ~stall & (((state == FETCH) & imem_ack) | (state == HELD));

  pipe_npc_mux #(.XLEN(XLEN)) u_npc_mux (
    .pc           (pc),
    .pcsource     (pcsource),
    .bpc          (bpc),
    .rpc          (rpc),
    .jpc          (jpc),
    .redirect_now (redirect_now),
    .redir_v      (redir_v),
    .redir_pc     (redir_pc),
    .npc          (npc)
  );

  // Fetch FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Fetch FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack && stall) state_next = HELD;
      HELD:    if (!stall) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Fetch FSM outputs: a request is raised only while waiting for a word
  always_comb begin
    imem_req = 1'b0;
    if (state == FETCH) imem_req = 1'b1;
  end

  // PC, pending delay-slot redirect, skid buffer and IF/ID register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc       <= RESET_PC;
      redir_v  <= 1'b0;
      redir_pc <= '0;
      skid     <= '0;
      skid_pc4 <= '0;
      inst     <= XLEN'(NOP_INST);
      dpc4     <= '0;
      id_valid <= 1'b0;
    end else begin
      if (advance) begin
        pc      <= npc;
        redir_v <= 1'b0;
      end else if (redirect_now) begin
        // npc equals the redirect target whenever redirect_now is set
        redir_v  <= 1'b1;
        redir_pc <= npc;
      end

      case (state)
        FETCH: begin
          if (!stall) begin
            if (imem_ack) begin
              inst     <= imem_rdata;
              dpc4     <= pc_plus4;
              id_valid <= 1'b1;
            end else begin
              inst     <= XLEN'(NOP_INST);
              id_valid <= 1'b0;
            end
          end else if (imem_ack) begin
            skid     <= imem_rdata;
            skid_pc4 <= pc_plus4;
          end
        end
        HELD: begin
          if (!stall) begin
            inst     <= skid;
            dpc4     <= skid_pc4;
            id_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Randomized bench for pipe_if_stage. The reference model works at the
// program-order level: every instruction ID consumes must be the next one
// in architectural order (PC+4, or the target of the instruction two
// before it when that one redirected), carrying the memory word for its
// address. Cycle-level rules (bubbles are NOPs, a stalled IF/ID never
// changes, a waiting request holds its address, no request while a word
// is parked) are checked alongside.
module tb_pipe_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ANY      = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, rpc = '0, jpc = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst, dpc4;
  logic        id_valid;

  always #5 clock = ~clock;

  pipe_if_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .dpc4       (dpc4),
    .id_valid   (id_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Stimulus knobs
  int ack_mode  = 0;   // 0: always ack, 1: fixed latency, 2: random
  int lat       = 0;
  int ack_pct   = 100;
  int stall_pct = 0;
  int redir_pct = 0;
  int stall_cnt = 0;
  bit force_on  = 0;
  logic [1:0]  f_src;
  logic [31:0] f_tgt, f_at;

  // Reference model and observation state
  logic [31:0] exp_addr, pend_tgt;
  bit          pend_v;
  int          wait_cnt;
  bit          prev_wait, prev_stall, held, gap_on, had_valid;
  logic [31:0] prev_addr, snap_inst, snap_dpc4;
  logic        snap_valid;
  int          gap;

  task automatic model_reset();
    exp_addr   = RESET_PC;
    pend_v     = 0;
    pend_tgt   = '0;
    wait_cnt   = 0;
    prev_wait  = 0;
    prev_stall = 0;
    held       = 0;
    had_valid  = 0;
    gap        = 0;
  endtask

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 1023)) << 2;
      1:       return 32'hFFFF_FFF8;
      2:       return 32'h0000_0100;
      default: return $urandom();
    endcase
  endfunction

  // ID consumes the instruction in IF/ID at the coming clock edge
  task automatic consume();
    logic [31:0] tgt, nxt;
    chk("inst", inst, mem_word(exp_addr));
    chk("dpc4", dpc4, exp_addr + 32'd4);
    $display("id addr=%h inst=%h pcsource=%0d", exp_addr, inst, pcsource);
    case (pcsource)
      2'b01:   tgt = bpc;
      2'b10:   tgt = rpc;
      2'b11:   tgt = jpc;
      default: tgt = '0;
    endcase
    nxt      = pend_v ? pend_tgt : exp_addr + 32'd4;
    pend_v   = (pcsource != 2'b00);
    pend_tgt = tgt;
    exp_addr = nxt;
  endtask

  task automatic check_cycle();
    if (prev_stall) begin
      chk("stall_inst", inst, snap_inst);
      chk("stall_dpc4", dpc4, snap_dpc4);
      chk("stall_valid", 32'(id_valid), 32'(snap_valid));
    end
    if (held) chk("held_req", 32'(imem_req), 32'd0);
    if (prev_wait) begin
      chk("addr_hold", imem_addr, prev_addr);
      chk("req_hold", 32'(imem_req), 32'd1);
    end
    if (!id_valid) chk("bubble_nop", inst, 32'd0);
    if (gap_on) begin
      if (id_valid) begin
        if (had_valid) chk("gap", 32'(gap), 32'(lat));
        had_valid = 1;
        gap = 0;
      end else begin
        gap++;
      end
    end
    if (id_valid && !stall) consume();
    if (held && !stall) held = 0;
    else if (imem_req && imem_ack && stall) held = 1;
    prev_stall = stall;
    snap_inst  = inst;
    snap_dpc4  = dpc4;
    snap_valid = id_valid;
    prev_wait  = imem_req && !imem_ack;
    prev_addr  = imem_addr;
  endtask

  // One clock: drive inputs just after the edge, check at the falling edge
  task automatic step();
    @(posedge clock);
    #1;
    stall    = ($urandom_range(0, 99) < stall_pct);
    pcsource = ($urandom_range(0, 99) < redir_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
    bpc = pick_tgt();
    rpc = pick_tgt();
    jpc = pick_tgt();
    if (stall_cnt > 0) begin
      stall = 1'b1;
      stall_cnt--;
    end
    if (force_on && id_valid && (f_at == ANY || dpc4 == f_at)) begin
      stall    = 1'b0;
      pcsource = f_src;
      bpc = f_tgt;
      rpc = f_tgt;
      jpc = f_tgt;
      force_on = 0;
    end
    case (ack_mode)
      0:       imem_ack = 1'b1;
      1:       imem_ack = (wait_cnt >= lat);
      default: imem_ack = ($urandom_range(0, 99) < ack_pct);
    endcase
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
    @(negedge clock);
    if (resetn) check_cycle();
    if (imem_req && !imem_ack) wait_cnt++;
    else wait_cnt = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] at);
    f_src = src;
    f_tgt = tgt;
    f_at  = at;
    force_on = 1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_dpc4"}, dpc4, 32'd0);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
  endtask

  // Release reset with a zero-wait memory and check the restart latency
  task automatic release_check();
    int  n = 0;
    bit  seen_req = 0;
    bit  found = 0;
    ack_mode  = 0;
    stall_pct = 0;
    redir_pct = 0;
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      n++;
      if (imem_req && !seen_req) begin
        seen_req = 1;
        chk("restart_addr", imem_addr, RESET_PC);
      end
      if (id_valid) found = 1;
    end
    chk("first_lat", 32'(n), 32'd2);
  endtask

  initial begin
    model_reset();
    #2 resetn = 1'b0;
    #1 check_reset_values("rst");
    repeat (2) @(posedge clock);
    release_check();

    // Zero-wait sequential fetch, then a branch at dpc4 = 0x14 to 0x100
    arm(2'b01, 32'h0000_0100, 32'h0000_0014);
    run(12);
    chk("branch_used", 32'(force_on), 32'd0);

    // Fixed 3-cycle ack latency with a branch: 3 bubbles per instruction
    ack_mode = 1; lat = 3; gap_on = 1; had_valid = 0;
    run(10);
    arm(2'b01, 32'h0000_0300, ANY);
    run(24);
    chk("lat3_branch_used", 32'(force_on), 32'd0);

    // Same with 2-cycle latency: delay slot via the remembered redirect
    lat = 2; had_valid = 0;
    run(6);
    arm(2'b01, 32'h0000_0100, ANY);
    run(20);
    chk("lat2_branch_used", 32'(force_on), 32'd0);
    gap_on = 0;

    // Zero-wait with a 3-cycle stall landing on an ack (skid path)
    ack_mode = 0;
    run(4);
    stall_cnt = 3;
    run(8);

    // PC wrap via a jump near the top of memory, then jr to 0x40
    arm(2'b11, 32'hFFFF_FFF8, ANY);
    run(6);
    chk("wrap_jump_used", 32'(force_on), 32'd0);
    arm(2'b10, 32'h0000_0040, ANY);
    run(6);
    chk("jr_used", 32'(force_on), 32'd0);

    // Random ack latency, stalls and redirects
    ack_mode = 2; ack_pct = 55; stall_pct = 25; redir_pct = 30;
    run(400);

    // Reset while the delay-slot fetch waits and a redirect is pending
    ack_mode = 1; lat = 3; stall_pct = 0; redir_pct = 0;
    run(6);
    arm(2'b01, 32'h0000_0500, ANY);
    for (int i = 0; i < 20 && force_on; i++) step();
    chk("mid_branch_used", 32'(force_on), 32'd0);
    @(posedge clock);
    #3 resetn = 1'b0;
    #1 check_reset_values("mid_rst");
    imem_ack = 1'b1;
    imem_rdata = $urandom();
    repeat (2) @(posedge clock);
    release_check();
    run(8);

    // Short random run after the restart
    ack_mode = 2; ack_pct = 70; stall_pct = 20; redir_pct = 30;
    run(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
